mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/arb_prio_sel.sv | 36 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and encodings for the instruction/data memory port arbiter.
// The arbitration policy is selected by the ARB_ROUND_ROBIN_EN macro.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Owner of the read whose data returns in the current cycle.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_D  = 2'd2
  } pend_e;

  // Winner of the most recent conflict (round-robin pointer).
  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_D  = 1'b1
  } winner_e;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant selector: one-hot grant from the two requests and the
// last-winner pointer. ARB_ROUND_ROBIN_EN selects alternation, else data wins.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  winner_e    last_winner,
  output logic [1:0] gnt
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority never consults the pointer.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    gnt = '0;
    if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_winner == WIN_D) gnt[GNT_IF] = 1'b1;
      else                      gnt[GNT_D]  = 1'b1;
`else
      gnt[GNT_D] = 1'b1;
`endif
    end else if (if_req) begin
      gnt[GNT_IF] = 1'b1;
    end else if (d_req) begin
      gnt[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single synchronous memory port with
// fixed read latency of 1. ARB_ROUND_ROBIN_EN enables round-robin on conflict.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]  sel;
  winner_e     last_winner;
  pend_e       pend;
  logic [31:0] conflict_cnt;
  logic        conflict;

  assign conflict = if_req && d_req;

  arb_prio_sel u_sel (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_winner (last_winner),
    .gnt         (sel)
  );

  // Grants are suppressed for the whole time reset is held.
  assign if_gnt = rst && sel[GNT_IF];
  assign d_gnt  = rst && sel[GNT_D];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Read data is steered straight from the memory in the cycle after the
  // grant; gating with rst drops a read that was in flight when reset hit.
  assign if_rvalid = rst && (pend == OWN_IF);
  assign d_rvalid  = rst && (pend == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend         <= NONE;
      conflict_cnt <= '0;
    end else begin
      if (if_gnt)              pend <= OWN_IF;
      else if (d_gnt && !d_we) pend <= OWN_D;
      else                     pend <= NONE;
      if (conflict) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer starts at D so that fetch wins the first conflict after reset.
  always_ff @(posedge clk) begin
    if (!rst)          last_winner <= WIN_D;
    else if (conflict) last_winner <= d_gnt ? WIN_D : WIN_IF;
  end
`else
  assign last_winner = WIN_D;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Transaction-level model: who is waiting for read data, from which
  // address, who won the last conflict, and how many conflicts were seen.
  int          m_pend = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_pend_addr = '0;
  bit          m_last_d = 1'b1;
  logic [31:0] m_cnt = '0;

  logic        o_if_gnt, o_d_gnt, o_mem_we, o_if_rv, o_d_rv;
  logic [31:0] o_mem_addr, o_mem_wdata, o_if_rd, o_d_rd;

  task automatic cycle();
    bit          both, e_if, e_d, e_ifrv, e_drv;
    logic [31:0] e_addr, e_wdata, e_ifrd, e_drd;
    @(negedge clk);
    both = if_req && d_req;
    e_if = 1'b0;
    e_d  = 1'b0;
    if (rst) begin
      if (both) begin
`ifdef ARB_ROUND_ROBIN_EN
        e_if = m_last_d;
        e_d  = !m_last_d;
`else
        e_d = 1'b1;
`endif
      end else begin
        e_if = if_req;
        e_d  = d_req;
      end
    end
    e_addr  = e_if ? if_addr : (e_d ? d_addr : 32'd0);
    e_wdata = e_d ? d_wdata : 32'd0;
    e_ifrv  = rst && (m_pend == 1);
    e_drv   = rst && (m_pend == 2);
    e_ifrd  = e_ifrv ? mem_word(m_pend_addr) : 32'd0;
    e_drd   = e_drv  ? mem_word(m_pend_addr) : 32'd0;

    check("gnt",       32'({if_gnt, d_gnt}),          32'({e_if, e_d}));
    check("mem_en_we", 32'({mem_en, mem_we}),         32'({e_if | e_d, e_d & d_we}));
    check("mem_addr",  mem_addr,  e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("rvalid",    32'({if_rvalid, d_rvalid}),    32'({e_ifrv, e_drv}));
    check("if_rdata",  if_rdata,  e_ifrd);
    check("d_rdata",   d_rdata,   e_drd);
    check("conflict_cnt", dut.conflict_cnt, m_cnt);

    o_if_gnt = if_gnt;  o_d_gnt = d_gnt;  o_mem_we = mem_we;
    o_mem_addr = mem_addr;  o_mem_wdata = mem_wdata;
    o_if_rv = if_rvalid;  o_d_rv = d_rvalid;  o_if_rd = if_rdata;  o_d_rd = d_rdata;

    @(posedge clk);
    if (!rst) begin
      m_pend   = 0;
      m_last_d = 1'b1;
      m_cnt    = '0;
    end else begin
      m_pend      = e_if ? 1 : ((e_d && !d_we) ? 2 : 0);
      m_pend_addr = e_if ? if_addr : d_addr;
      if (both) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_last_d = e_d;
      end
    end
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [4];
    @(posedge clk);
    #1;

    // Reset held with both requests active: no grants, nothing counted.
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h14;
    repeat (2) cycle();
    check("rst_no_gnt", 32'({o_if_gnt, o_d_gnt}), 32'd0);
    check("rst_pend",   32'(dut.pend), 32'd0);

    // Both requests held for four cycles straight out of reset.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq[i] = {o_if_gnt, o_d_gnt};
    end
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check("conflict_seq", 32'(seq[i]), (i % 2 == 0) ? 32'b10 : 32'b01);
`else
      check("conflict_seq", 32'(seq[i]), 32'b01);
`endif
    end
    check("conflict_cnt4", dut.conflict_cnt, 32'd4);
    idle();
    cycle();

    // Lone fetch read: granted immediately, data one cycle later.
    if_req = 1'b1; if_addr = 32'h8;
    cycle();
    check("if_gnt_alone", 32'(o_if_gnt), 32'd1);
    check("if_mem_addr",  o_mem_addr, 32'h8);
    idle();
    cycle();
    check("if_rvalid",    32'(o_if_rv), 32'd1);
    check("if_rdata",     o_if_rd, mem_word(32'h8));

    // Data write: no read response follows.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5;
    cycle();
    check("d_wr_gnt",   32'({o_d_gnt, o_mem_we}), 32'b11);
    check("d_wr_wdata", o_mem_wdata, 32'h5);
    idle();
    cycle();
    check("d_wr_no_rv", 32'(o_d_rv), 32'd0);

    // Back-to-back fetch read then data read.
    if_req = 1'b1; if_addr = 32'h100;
    cycle();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
    cycle();
    check("b2b_if_rv",  32'({o_if_rv, o_d_gnt}), 32'b11);
    check("b2b_if_rd",  o_if_rd, mem_word(32'h100));
    idle();
    cycle();
    check("b2b_d_rv",   32'({o_if_rv, o_d_rv}), 32'b01);
    check("b2b_d_rd",   o_d_rd, mem_word(32'h204));

    // Reset lands right after a read grant: its data must be dropped.
    if_req = 1'b1; if_addr = 32'h40;
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    check("rst_drop_n1", 32'({o_if_rv, o_d_rv}), 32'd0);
    rst = 1'b1;
    cycle();
    check("rst_drop_n2", 32'({o_if_rv, o_d_rv}), 32'd0);
    check("rst_drop_pend", 32'(dut.pend), 32'd0);

    // Counter saturation from one below the top.
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt;
    m_cnt = 32'hFFFF_FFFE;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    cycle();
    check("sat_top",  dut.conflict_cnt, 32'hFFFF_FFFF);
    cycle();
    check("sat_hold", dut.conflict_cnt, 32'hFFFF_FFFF);
    idle();
    cycle();

    // Random traffic: a request is held until granted, occasional resets.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      if (!(if_req && !o_if_gnt)) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(d_req && !o_d_gnt)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
